// File: rtl/flags_state_if.sv
// Bundle between the controller/condition-check side (master) and the flag register (slave).
interface flags_state_if #(
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [3:0]    FlagsNext;
  logic          Advance;
  logic          Save;
  logic          Restore;
  logic [3:0]    Flags;
  logic [DW-1:0] Depth;
  logic          Empty;
  logic          Full;
  logic          OvfErr;
  logic          UndErr;

  modport master (
    output FlagsNext, Advance, Save, Restore,
    input  Flags, Depth, Empty, Full, OvfErr, UndErr
  );

  modport slave (
    input  FlagsNext, Advance, Save, Restore,
    output Flags, Depth, Empty, Full, OvfErr, UndErr
  );
endinterface

// File: rtl/flags_state.sv
// NZCV flag register with a LIFO shadow stack for exception save/restore.
// Define FLAGS_SHADOW_EN to build the stack; without it Save/Restore are ignored.
module flags_state #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  flags_state_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [3:0] flags_q;
  logic [3:0] flags_d;

`ifdef FLAGS_SHADOW_EN
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    stack [DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;
  logic          empty_q;
  logic          full_q;
  logic          ovf_q;
  logic          und_q;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          ovf_set;
  logic          und_set;

  always_comb begin
    flags_d = flags_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = IW'(depth_q);
    top_idx = IW'(depth_q - 1'b1);
    ovf_set = 1'b0;
    und_set = 1'b0;
    if (bus.Restore && !empty_q) begin
      // Restore wins over Advance; with Save it becomes an in-place exchange of the top entry.
      flags_d = stack[top_idx];
      if (bus.Save) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        depth_d = depth_q - 1'b1;
      end
    end else begin
      if (bus.Advance) flags_d = bus.FlagsNext;
      und_set = bus.Restore;
      if (bus.Save) begin
        if (full_q) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          depth_d = depth_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      depth_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      empty_q <= (depth_d == '0);
      full_q  <= (depth_d == DW'(DEPTH));
      ovf_q   <= ovf_q | ovf_set;
      und_q   <= und_q | und_set;
    end
  end

  // Stack storage has no reset; clearing depth_q is enough to discard entries.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) stack[wr_idx] <= flags_q;
  end

  assign bus.Depth  = depth_q;
  assign bus.Empty  = empty_q;
  assign bus.Full   = full_q;
  assign bus.OvfErr = ovf_q;
  assign bus.UndErr = und_q;
`else
  logic unused_stack_ctl;

  always_comb begin
    flags_d = flags_q;
    if (bus.Advance) flags_d = bus.FlagsNext;
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign unused_stack_ctl = bus.Save ^ bus.Restore;
  assign bus.Depth  = '0;
  assign bus.Empty  = 1'b1;
  assign bus.Full   = 1'b0;
  assign bus.OvfErr = 1'b0;
  assign bus.UndErr = 1'b0;
`endif

  assign bus.Flags = flags_q;
endmodule

// File: tb/tb_flags_state.sv
// Directed table-driven bench for flags_state (DEPTH = 4); expectations follow FLAGS_SHADOW_EN.
module tb_flags_state;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  flags_state_if #(.DEPTH(DEPTH)) bus ();

  flags_state #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       sv;
    logic       rs;
    logic       adv;
    logic [3:0] nxt;
    logic [3:0] f;
    logic [2:0] d;
    logic       o;
    logic       u;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rst, logic sv, logic rs, logic adv, logic [3:0] nxt,
                              logic [3:0] f, logic [2:0] d, logic o, logic u);
    vec_t v;
    v.rst = rst; v.sv = sv; v.rs = rs; v.adv = adv; v.nxt = nxt;
    v.f = f; v.d = d; v.o = o; v.u = u;
    return v;
  endfunction

  function automatic logic [10:0] exp_of(vec_t v);
    return {v.f, v.d, (v.d == 3'd0), (v.d == 3'(DEPTH)), v.o, v.u};
  endfunction

  function automatic logic [10:0] got_now();
    return {bus.Flags, bus.Depth, bus.Empty, bus.Full, bus.OvfErr, bus.UndErr};
  endfunction

  task automatic check(string name, logic [10:0] exp);
    logic [10:0] got;
    got = got_now();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got flags=%b depth=%0d empty=%b full=%b ovf=%b und=%b, want flags=%b depth=%0d empty=%b full=%b ovf=%b und=%b",
               name, got[10:7], got[6:4], got[3], got[2], got[1], got[0],
               exp[10:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(vec_t v);
    reset         = v.rst;
    bus.Save      = v.sv;
    bus.Restore   = v.rs;
    bus.Advance   = v.adv;
    bus.FlagsNext = v.nxt;
  endtask

  initial begin
    vec_t last;
    vec_t nv;
`ifdef FLAGS_SHADOW_EN
    //                rst sv rs adv nxt    f   d  o  u
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'hA, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h5, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'h6, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'h9, 4'h9, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'h1, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h2, 4'h2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h3, 4'h3, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h4, 4'h4, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h5, 4'h5, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h5, 4, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'hF, 4'h4, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h3, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'h3, 4'h3, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 4'hC, 4'hC, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 4'hF, 4'h3, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hC, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 4'h5, 4'h5, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hC, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h7, 4'h7, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h8, 4'h8, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h9, 4'h9, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'hA, 4'hA, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'h0, 4'h9, 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hA, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'hA, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'hA, 4, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hA, 3, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hF, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 0, 0, 1));
`else
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'hA, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 4'h6, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h3, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'h3, 4'h3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hF, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), exp_of(vecs[i]));
    end

    // Inputs changing mid-cycle must not reach the outputs before the next edge.
    last = vecs[vecs.size()-1];
    nv = mk(0, 1, 0, 1, 4'hE, 4'hE, 0, 0, 0);
`ifdef FLAGS_SHADOW_EN
    nv.d = 3'd1;
    nv.u = 1'b1;
`endif
    drive(nv);
    #2;
    check("no_comb_path", exp_of(last));
    @(posedge clk);
    #1;
    check("after_edge", exp_of(nv));

    // Reset with all controls asserted and a pending Advance.
    nv = mk(1, 1, 1, 1, 4'h7, 4'h0, 0, 0, 0);
    drive(nv);
    @(posedge clk);
    #1;
    check("reset_overrides", exp_of(nv));
    reset = 1'b0;
    bus.Save = 1'b0;
    bus.Restore = 1'b0;
    bus.Advance = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", exp_of(nv));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/flags_state.md
# flags_state

Architectural NZCV flag register for the multicycle ARM-subset core, with a LIFO shadow stack for flag save/restore on exception entry and return. It drives `Flags` to the condition-check unit and accepts that unit's resolved `FlagsNext` on each controller `Advance` strobe. All outputs are registered. Stack status and sticky error flags are exported to the controller and the debug block.

## Interface
- `DEPTH`, default 4: shadow stack entries, legal range 1..16.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `FlagsNext` input 4: resolved next flags `{N,Z,C,V}` from the condition-check unit.
- `Advance` input 1: controller strobe; commit `FlagsNext` this cycle.
- `Save` input 1: push current `Flags` onto the shadow stack (exception entry).
- `Restore` input 1: pop the stack top into `Flags` (exception return).
- `Flags` output 4: architectural `{N,Z,C,V}`.
- `Depth` output $clog2(DEPTH+1): number of valid stack entries.
- `Empty` output 1: `Depth == 0`.
- `Full` output 1: `Depth == DEPTH`.
- `OvfErr` output 1: sticky; a Save was attempted while Full.
- `UndErr` output 1: sticky; a Restore was attempted while Empty.

## Operation
- Reset values: `Flags` = 4'b0000, `Depth` = 0, `Empty` = 1, `Full` = 0, `OvfErr` = 0, `UndErr` = 0. Stack RAM contents are undefined and not observable.
- Per-cycle resolution. "Pre-edge" means the registered value at the start of the cycle.
  - **Restore only, not Empty:** `Flags` <= top entry; `Depth` -1. `Advance` is ignored.
  - **Restore only, Empty:** `UndErr` <= 1. `Flags` follows `Advance` normally.
  - **Save only, not Full:** push pre-edge `Flags`; `Depth` +1. `Flags` follows `Advance`.
  - **Save only, Full:** no push; `Depth` unchanged; `OvfErr` <= 1. `Flags` follows `Advance`.
  - **Save and Restore, not Empty:** atomic exchange. The top entry <= pre-edge `Flags`; `Flags` <= old top; `Depth` unchanged. `Advance` is ignored. This holds even when Full, and does not set `OvfErr`.
  - **Save and Restore, Empty:** `UndErr` <= 1. Save pushes as normal; `Flags` follows `Advance`.
  - **Neither:** `Flags` <= `FlagsNext` if `Advance`, otherwise hold.
- `Depth` never wraps. It saturates at 0 and at `DEPTH` through the rules above.
- `OvfErr` and `UndErr` clear only on `reset`.
- `reset` overrides every other input in the same cycle. A reset mid-nest discards all stacked entries.

## Timing
- 1-cycle latency. Outputs reflect the effects of a cycle's inputs after that cycle's rising edge.
- There is no combinational path from any input to any output.
- `Save`, `Restore` and `Advance` are level-sampled every cycle. There is no handshake; the controller must assert each for exactly one cycle per operation.
- Back-to-back operations are legal in every cycle, including alternating Save/Restore.

## Configuration
- `FLAGS_SHADOW_EN` defined: shadow stack, `Depth`, `Full`, `Empty`, `OvfErr` and `UndErr` behave as above.
- `FLAGS_SHADOW_EN` undefined: no stack storage is built.
  - `Save` and `Restore` are ignored; `Flags` updates only on `Advance`.
  - `Depth` = 0, `Empty` = 1, `Full` = 0, `OvfErr` = 0 and `UndErr` = 0 at all times.

## Test plan
- Reset, then `Advance` with `FlagsNext` = 4'b1010 -> `Flags` = 4'b1010 one cycle later; without `Advance`, `Flags` holds.
- `Flags` = 4'b0110; Save; Advance with 4'b1001; Restore -> `Flags` = 4'b0110, `Depth` sequence 0,1,0, and `Empty` reasserts.
- `DEPTH` = 4: five Saves with `Flags` at 1,2,3,4,5 -> `Full` = 1 and `OvfErr` = 1 after the fifth. Four Restores then yield 4,3,2,1; a fifth Restore sets `UndErr` and leaves `Flags` = 1.
- `Depth` = 1 with top 4'b0011, `Flags` = 4'b1100, Save+Restore+Advance(4'b1111) together -> `Flags` = 4'b0011, `Depth` = 1; a following Restore gives `Flags` = 4'b1100.
- `Depth` = 3 and `OvfErr` = 1, then assert `reset` together with Save -> `Flags` = 0, `Depth` = 0, `Empty` = 1, both error flags 0.
- Build without `FLAGS_SHADOW_EN`: Save/Restore pulses leave `Flags` unchanged; `Depth` = 0 and `Empty` = 1 throughout.
